alu_op_sequencer: RTL

- Hardwired control sequencer for register-to-register ALU instructions on the single-bus datapath.
- On a Start pulse it runs the instruction fetch, decodes the latched IR, and drives the per-T-state bus, register and ALU-select strobes to completion.
- Supersedes hand-scripted T0–T5 stimulus: register count is parametrised, opcode/register fields are decoded, and the sequence length varies (3-op, MUL/DIV, NEG/NOT) with Start/Busy/Done handshake and illegal-op detection.

---
 rtl/alu_op_sequencer.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// Hardwired control sequencer for single-bus reg-to-reg ALU instructions: fetch, decode, per-T-state strobes.
// Optional MUL/DIV sequencing (T6, HIin/LOin/Zhighout) is built only when MULDIV_EN is defined.
module alu_op_sequencer #(
  parameter int REG_COUNT = 16,
  parameter int OPC_WIDTH = 5
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [31:0]          IR,
  output logic                 PCout,
  output logic                 Zlowout,
  output logic                 Zhighout,
  output logic                 MDRout,
  output logic                 MARin,
  output logic                 PCin,
  output logic                 MDRin,
  output logic                 IRin,
  output logic                 Yin,
  output logic                 Zin,
  output logic                 HIin,
  output logic                 LOin,
  output logic                 IncPC,
  output logic                 Read,
  output logic [REG_COUNT-1:0] Rin,
  output logic [REG_COUNT-1:0] Rout,
  output logic [3:0]           AluOp,
  output logic                 Busy,
  output logic                 Done,
  output logic                 IllegalOp
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5,
`ifdef MULDIV_EN
    S_T6,
`endif
    S_FIN, S_ERR
  } state_t;

  typedef enum logic [1:0] {C_3OP, C_MULDIV, C_UNARY, C_BAD} cls_t;

  typedef struct packed {
    logic                 pc_out;
    logic                 zlow_out;
    logic                 mdr_out;
    logic                 mar_in;
    logic                 pc_in;
    logic                 mdr_in;
    logic                 ir_in;
    logic                 y_in;
    logic                 z_in;
    logic                 inc_pc;
    logic                 read;
    logic [REG_COUNT-1:0] rin;
    logic [REG_COUNT-1:0] rout;
    logic [3:0]           alu_op;
    logic                 busy;
    logic                 done;
    logic                 illegal;
  } ctl_t;

  localparam logic [OPC_WIDTH-1:0] OP_ADD  = OPC_WIDTH'(3);
  localparam logic [OPC_WIDTH-1:0] OP_SUB  = OPC_WIDTH'(4);
  localparam logic [OPC_WIDTH-1:0] OP_AND  = OPC_WIDTH'(5);
  localparam logic [OPC_WIDTH-1:0] OP_OR   = OPC_WIDTH'(6);
  localparam logic [OPC_WIDTH-1:0] OP_SHR  = OPC_WIDTH'(7);
  localparam logic [OPC_WIDTH-1:0] OP_SHRA = OPC_WIDTH'(8);
  localparam logic [OPC_WIDTH-1:0] OP_SHL  = OPC_WIDTH'(9);
  localparam logic [OPC_WIDTH-1:0] OP_ROR  = OPC_WIDTH'(10);
  localparam logic [OPC_WIDTH-1:0] OP_ROL  = OPC_WIDTH'(11);
`ifdef MULDIV_EN
  localparam logic [OPC_WIDTH-1:0] OP_MUL  = OPC_WIDTH'(15);
  localparam logic [OPC_WIDTH-1:0] OP_DIV  = OPC_WIDTH'(16);
`endif
  localparam logic [OPC_WIDTH-1:0] OP_NEG  = OPC_WIDTH'(17);
  localparam logic [OPC_WIDTH-1:0] OP_NOT  = OPC_WIDTH'(18);

  localparam logic [4:0]           REG_LIM = 5'(REG_COUNT);
  localparam logic [REG_COUNT-1:0] ONE     = REG_COUNT'(1);

  function automatic logic [REG_COUNT-1:0] onehot(input logic [3:0] idx);
    onehot = ONE << idx;
  endfunction

  state_t               state, nxt;
  ctl_t                 ctl_d, ctl_q;
  logic [OPC_WIDTH-1:0] opc;
  logic [3:0]           ra_f, rb_f, rc_f;
  logic                 ra_bad, rb_bad, rc_bad;
  logic                 unused_ir;
  cls_t                 dec_cls, cls_q, e_cls;
  logic [3:0]           dec_alu, alu_q, e_alu;
  logic [3:0]           ra_q, rb_q, rc_q, e_ra, e_rb, e_rc;

  assign opc       = IR[31 -: OPC_WIDTH];
  assign ra_f      = IR[26:23];
  assign rb_f      = IR[22:19];
  assign rc_f      = IR[18:15];
  assign unused_ir = ^IR[14:0];
  assign ra_bad    = {1'b0, ra_f} >= REG_LIM;
  assign rb_bad    = {1'b0, rb_f} >= REG_LIM;
  assign rc_bad    = {1'b0, rc_f} >= REG_LIM;

  always_comb begin
    dec_cls = C_BAD;
    dec_alu = 4'h0;
    case (opc)
      OP_ADD:  begin dec_cls = C_3OP;    dec_alu = 4'h2; end
      OP_SUB:  begin dec_cls = C_3OP;    dec_alu = 4'h3; end
      OP_AND:  begin dec_cls = C_3OP;    dec_alu = 4'h0; end
      OP_OR:   begin dec_cls = C_3OP;    dec_alu = 4'h1; end
      OP_SHR:  begin dec_cls = C_3OP;    dec_alu = 4'h7; end
      OP_SHRA: begin dec_cls = C_3OP;    dec_alu = 4'h8; end
      OP_SHL:  begin dec_cls = C_3OP;    dec_alu = 4'h9; end
      OP_ROR:  begin dec_cls = C_3OP;    dec_alu = 4'hA; end
      OP_ROL:  begin dec_cls = C_3OP;    dec_alu = 4'hB; end
`ifdef MULDIV_EN
      OP_MUL:  begin dec_cls = C_MULDIV; dec_alu = 4'h4; end
      OP_DIV:  begin dec_cls = C_MULDIV; dec_alu = 4'h6; end
`endif
      OP_NEG:  begin dec_cls = C_UNARY;  dec_alu = 4'hC; end
      OP_NOT:  begin dec_cls = C_UNARY;  dec_alu = 4'hD; end
      default: ;
    endcase
    // Rc is only a real operand for the three-operand class
    if ((dec_cls == C_3OP && (ra_bad || rb_bad || rc_bad)) ||
        (dec_cls != C_3OP && (ra_bad || rb_bad)))
      dec_cls = C_BAD;
  end

  // T3 strobes are computed while still in T2, before the decode is latched
  assign e_cls = (state == S_T2) ? dec_cls : cls_q;
  assign e_alu = (state == S_T2) ? dec_alu : alu_q;
  assign e_ra  = (state == S_T2) ? ra_f    : ra_q;
  assign e_rb  = (state == S_T2) ? rb_f    : rb_q;
  assign e_rc  = (state == S_T2) ? rc_f    : rc_q;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (Start) nxt = S_T0;
      S_T0:   nxt = S_T1;
      S_T1:   nxt = S_T2;
      S_T2:   nxt = (dec_cls == C_BAD) ? S_ERR : S_T3;
      S_T3:   nxt = S_T4;
      S_T4:   nxt = (cls_q == C_UNARY) ? S_FIN : S_T5;
`ifdef MULDIV_EN
      S_T5:   nxt = (cls_q == C_MULDIV) ? S_T6 : S_FIN;
      S_T6:   nxt = S_FIN;
`else
      S_T5:   nxt = S_FIN;
`endif
      S_FIN:  nxt = S_IDLE;
      S_ERR:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

`ifdef MULDIV_EN
  logic zhigh_d, hi_d, lo_d, zhigh_q, hi_q, lo_q;
`endif

  always_comb begin
    ctl_d      = '0;
`ifdef MULDIV_EN
    zhigh_d    = 1'b0;
    hi_d       = 1'b0;
    lo_d       = 1'b0;
`endif
    ctl_d.busy = (nxt != S_IDLE);
    case (nxt)
      S_T0: begin
        ctl_d.pc_out = 1'b1;
        ctl_d.mar_in = 1'b1;
        ctl_d.inc_pc = 1'b1;
        ctl_d.z_in   = 1'b1;
      end
      S_T1: begin
        ctl_d.zlow_out = 1'b1;
        ctl_d.pc_in    = 1'b1;
        ctl_d.read     = 1'b1;
        ctl_d.mdr_in   = 1'b1;
      end
      S_T2: begin
        ctl_d.mdr_out = 1'b1;
        ctl_d.ir_in   = 1'b1;
      end
      S_T3: begin
        ctl_d.rout = (e_cls == C_MULDIV) ? onehot(e_ra) : onehot(e_rb);
        if (e_cls == C_UNARY) begin
          ctl_d.alu_op = e_alu;
          ctl_d.z_in   = 1'b1;
        end else begin
          ctl_d.y_in = 1'b1;
        end
      end
      S_T4: begin
        if (e_cls == C_UNARY) begin
          ctl_d.zlow_out = 1'b1;
          ctl_d.rin      = onehot(e_ra);
        end else begin
          ctl_d.rout   = (e_cls == C_3OP) ? onehot(e_rc) : onehot(e_rb);
          ctl_d.alu_op = e_alu;
          ctl_d.z_in   = 1'b1;
        end
      end
      S_T5: begin
        ctl_d.zlow_out = 1'b1;
`ifdef MULDIV_EN
        if (e_cls == C_MULDIV) lo_d = 1'b1;
        else                   ctl_d.rin = onehot(e_ra);
`else
        ctl_d.rin = onehot(e_ra);
`endif
      end
`ifdef MULDIV_EN
      S_T6: begin
        zhigh_d = 1'b1;
        hi_d    = 1'b1;
      end
`endif
      S_FIN: ctl_d.done = 1'b1;
      S_ERR: begin
        ctl_d.done    = 1'b1;
        ctl_d.illegal = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      ctl_q <= '0;
      cls_q <= C_BAD;
      alu_q <= 4'h0;
      ra_q  <= 4'h0;
      rb_q  <= 4'h0;
      rc_q  <= 4'h0;
    end else begin
      state <= nxt;
      ctl_q <= ctl_d;
      if (state == S_T2) begin
        cls_q <= dec_cls;
        alu_q <= dec_alu;
        ra_q  <= ra_f;
        rb_q  <= rb_f;
        rc_q  <= rc_f;
      end
    end
  end

`ifdef MULDIV_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      zhigh_q <= 1'b0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      zhigh_q <= zhigh_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  assign Zhighout = zhigh_q;
  assign HIin     = hi_q;
  assign LOin     = lo_q;
`else
  assign Zhighout = 1'b0;
  assign HIin     = 1'b0;
  assign LOin     = 1'b0;
`endif

  assign PCout     = ctl_q.pc_out;
  assign Zlowout   = ctl_q.zlow_out;
  assign MDRout    = ctl_q.mdr_out;
  assign MARin     = ctl_q.mar_in;
  assign PCin      = ctl_q.pc_in;
  assign MDRin     = ctl_q.mdr_in;
  assign IRin      = ctl_q.ir_in;
  assign Yin       = ctl_q.y_in;
  assign Zin       = ctl_q.z_in;
  assign IncPC     = ctl_q.inc_pc;
  assign Read      = ctl_q.read;
  assign Rin       = ctl_q.rin;
  assign Rout      = ctl_q.rout;
  assign AluOp     = ctl_q.alu_op;
  assign Busy      = ctl_q.busy;
  assign Done      = ctl_q.done;
  assign IllegalOp = ctl_q.illegal;

endmodule
